arst_seq: RTL
=============

ARST_SEQ -- requirements
Module: arst_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of reset-release synchronizer flops (legal >= 2).
REQ-002 SHALL have parameter PULSE_CYC, default 4, width in clk cycles of every generated set/clear pulse and of the post-reset hold (legal >= 1).
REQ-003 SHALL have parameter GAP_CYC, default 1, cycles with both outputs deasserted before and after every pulse (legal >= 1).
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port set_req  input  1  request a set pulse on set_out_b (level, sampled only when req_ready=1).
REQ-007 SHALL have port clr_req  input  1  request a clear pulse on rst_out_b (level, sampled only when req_ready=1).
REQ-008 SHALL have port rst_out_b  output  1  active-low asynchronous clear to downstream set/reset flops.
REQ-009 SHALL have port set_out_b  output  1  active-low asynchronous preset to downstream set/reset flops.
REQ-010 SHALL have port req_ready  output  1  high only in IDLE; request accepted on an edge where req_ready=1 and a request is high.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking completion of an accepted request.

Function
REQ-012 SHALL implement states RST, SYNC, HOLD, IDLE, PRE, PULSE, POST; all outputs driven from flops, no combinational output paths.
REQ-013 SHALL never drive rst_out_b=0 and set_out_b=0 simultaneously, in any state, including across reset assertion/release.
REQ-014 SHALL, in SYNC, shift 1 through SYNC_STAGES flops; SYNC->HOLD when the last stage is 1.
REQ-015 SHALL hold rst_out_b=0 in HOLD for PULSE_CYC cycles; rst_out_b rises on rising edge number SYNC_STAGES+PULSE_CYC after resetb deasserts (6th edge at defaults); same edge HOLD->IDLE.
REQ-016 SHALL, in IDLE, accept clr_req with priority over set_req; when both high, only the clear is performed, set request dropped (not queued).
REQ-017 SHALL, for request accepted at edge E0: both outputs high through PRE; selected output falls at edge E0+GAP_CYC; rises at E0+GAP_CYC+PULSE_CYC; POST lasts GAP_CYC cycles; done=1 and req_ready=1 after edge E0+2*GAP_CYC+PULSE_CYC (E0+1, E0+5, E0+6 at defaults).
REQ-018 SHALL ignore set_req/clr_req changes while req_ready=0; a request still high when IDLE is re-entered is accepted on the next edge (back-to-back pulses separated by at least 2*GAP_CYC idle-high cycles).
REQ-019 SHALL use one down-counter of width clog2(max(PULSE_CYC,GAP_CYC))+1 shared by HOLD/PRE/PULSE/POST, reloaded on each state entry; no wrap permitted.
REQ-020 SHALL assert done for exactly one cycle per accepted request and never during reset sequencing.

Reset
REQ-021 SHALL, on resetb falling, immediately (no clk required) force rst_out_b=0, set_out_b=1, req_ready=0, done=0, synchronizer flops=0, counter=0, state=RST.
REQ-022 SHALL, if resetb asserts mid-pulse (any state), abort the operation with no done pulse; a set pulse in progress ends with set_out_b=1 in the same instant rst_out_b falls.
REQ-023 SHALL move RST->SYNC on the first rising edge with resetb=1; a resetb glitch shorter than a cycle still restarts the full SYNC+HOLD sequence.

Verification
REQ-024 Reset release at defaults: resetb 0->1 between edges, no requests -> rst_out_b=0 through edge 5, rises at edge 6, req_ready=1 after edge 6, set_out_b=1 throughout.
REQ-025 Set request: set_req=1 accepted at E0 -> set_out_b falls at E0+1, rises at E0+5, done=1 for one cycle after E0+6, rst_out_b=1 throughout.
REQ-026 Simultaneous set_req=1, clr_req=1 at E0 -> rst_out_b low E0+1..E0+5, set_out_b stays 1, single done at E0+6.
REQ-027 Reset mid-pulse: resetb=0 at E0+3 during set pulse -> same instant set_out_b=1, rst_out_b=0; no done; full 6-edge release sequence after resetb=1.
REQ-028 Overlap invariant: randomized requests and resetb toggles over 10000 cycles, all parameter sets (2,4,1),(3,1,2),(2,7,3) -> assertion rst_out_b|set_out_b always 1; request during busy ignored; done count equals accepted-request count.

Source files
------------

// File: rtl/arst_seq_if.sv
// ---------------------------------------------------------------------------
// arst_seq_if
// Request/response bundle between a reset-sequencer client and arst_seq.
//
// Signals:
//   set_req    client -> sequencer  request a set pulse on set_out_b (level)
//   clr_req    client -> sequencer  request a clear pulse on rst_out_b (level)
//   rst_out_b  sequencer -> client  active-low asynchronous clear, downstream
//   set_out_b  sequencer -> client  active-low asynchronous preset, downstream
//   req_ready  sequencer -> client  high only while the sequencer is idle
//   done       sequencer -> client  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface arst_seq_if;
   logic set_req;
   logic clr_req;
   logic rst_out_b;
   logic set_out_b;
   logic req_ready;
   logic done;

   modport master (
      output set_req,
      output clr_req,
      input  rst_out_b,
      input  set_out_b,
      input  req_ready,
      input  done
   );

   modport slave (
      input  set_req,
      input  clr_req,
      output rst_out_b,
      output set_out_b,
      output req_ready,
      output done
   );
endinterface

// File: rtl/arst_seq.sv
// ---------------------------------------------------------------------------
// arst_seq
// Reset/preset pulse sequencer for downstream set/reset flops. After resetb
// is released the release is synchronised, rst_out_b is held low for a
// further PULSE_CYC cycles, and then set/clear pulse requests are served one
// at a time, each framed by GAP_CYC cycles with both outputs high.
// rst_out_b and set_out_b are never low together.
//
// Ports:
//   clk     input   clock, all state changes on the rising edge
//   resetb  input   asynchronous active-low reset
//   bus_if  slave   set_req/clr_req in; rst_out_b/set_out_b/req_ready/done out
//
// Parameters:
//   SYNC_STAGES  reset-release synchroniser depth (>= 2)
//   PULSE_CYC    width of every pulse and of the post-reset hold (>= 1)
//   GAP_CYC      idle-high cycles before and after every pulse (>= 1)
// ---------------------------------------------------------------------------
module arst_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_CYC   = 4,
   parameter int GAP_CYC     = 1
) (
   input logic       clk,
   input logic       resetb,
   arst_seq_if.slave bus_if
);

   localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   // Counter reload values: a phase of N cycles counts N-1 down to zero.
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_SYNC  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_IDLE  = 3'd3,
      ST_PRE   = 3'd4,
      ST_PULSE = 3'd5,
      ST_POST  = 3'd6
   } state_e;

   state_e                 state_q,     state_d;
   logic [SYNC_STAGES-1:0] sync_q,      sync_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic                   sel_clr_q,   sel_clr_d;
   logic                   rst_out_b_q, rst_out_b_d;
   logic                   set_out_b_q, set_out_b_d;
   logic                   req_ready_q, req_ready_d;
   logic                   done_q,      done_d;

   // State, synchroniser, counter and output flops; resetb forces the safe state at once.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= ST_RST;
         sync_q      <= {SYNC_STAGES{1'b0}};
         cnt_q       <= CNT_ZERO;
         sel_clr_q   <= 1'b0;
         rst_out_b_q <= 1'b0;
         set_out_b_q <= 1'b1;
         req_ready_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         sel_clr_q   <= sel_clr_d;
         rst_out_b_q <= rst_out_b_d;
         set_out_b_q <= set_out_b_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
      end
   end

   // Next-state, counter and next-output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_clr_d = sel_clr_q;
      done_d    = 1'b0;
      // The chain keeps shifting ones in; it saturates once fully released.
      sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};

      case (state_q)
         ST_RST: begin
            state_d = ST_SYNC;
         end
         ST_SYNC: begin
            // Leave on the edge that sets the last stage so the hold ends on
            // edge SYNC_STAGES+PULSE_CYC after release.
            if (sync_d[SYNC_STAGES-1]) begin
               state_d = ST_HOLD;
               cnt_d   = PULSE_LOAD;
            end else begin
               state_d = ST_SYNC;
            end
         end
         ST_HOLD: begin
            // Last synchroniser stage doubles as an interlock on release.
            if ((cnt_q == CNT_ZERO) && sync_q[SYNC_STAGES-1]) begin
               state_d = ST_IDLE;
            end else if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               cnt_d = CNT_ZERO;
            end
         end
         ST_IDLE: begin
            // Clear wins over set; a simultaneous set request is dropped.
            if (bus_if.clr_req || bus_if.set_req) begin
               state_d   = ST_PRE;
               cnt_d     = GAP_LOAD;
               sel_clr_d = bus_if.clr_req;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_POST;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_POST: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_RST;
            cnt_d   = CNT_ZERO;
         end
      endcase

      // Outputs are decoded from the next state so they register with it.
      // Only one of the two active-low outputs can be low in any state.
      rst_out_b_d = 1'b1;
      set_out_b_d = 1'b1;
      case (state_d)
         ST_RST, ST_SYNC, ST_HOLD: begin
            rst_out_b_d = 1'b0;
         end
         ST_PULSE: begin
            if (sel_clr_d) begin
               rst_out_b_d = 1'b0;
            end else begin
               set_out_b_d = 1'b0;
            end
         end
         default: begin
            rst_out_b_d = 1'b1;
            set_out_b_d = 1'b1;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   assign bus_if.rst_out_b = rst_out_b_q;
   assign bus_if.set_out_b = set_out_b_q;
   assign bus_if.req_ready = req_ready_q;
   assign bus_if.done      = done_q;

endmodule
